request_unit: RTL and testbench

Sequential memory-request sequencer for the single-cycle datapath. It takes the data-access intents (dRENi/dWENi) and halt indication produced by decode of the current instruction and turns them into held memory requests (dREN/dWEN) toward the memory interface. It also generates the PC enable and the instruction-read enable. A saturating counter records data-stall cycles for performance bring-up.

---
 rtl/request_unit.sv | 126 ++++++++++++
 tb/tb_request_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/request_unit.sv
// Memory-request sequencer: turns decoded data-access intents into held dREN/dWEN
// requests, drives PC/fetch enables, and counts data-stall cycles (saturating).
//
// state  | meaning
// IDLE   | waiting for ihit; launches a data request, a halt, or advances the PC
// DREQ   | data request held toward memory until dhit
// HALTED | terminal; all inputs ignored until reset
module request_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dRENi,
  input  logic             dWENi,
  input  logic             halt_i,
  output logic             dREN,
  output logic             dWEN,
  output logic             iREN,
  output logic             pcEN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DREQ   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic             r_dren;
  logic             r_dwen;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;

  state_t           w_state_nxt;
  logic             w_dren_nxt;
  logic             w_dwen_nxt;
  logic             w_halt_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic             w_pc_en;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_dren      <= 1'b0;
      r_dwen      <= 1'b0;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dren      <= w_dren_nxt;
      r_dwen      <= w_dwen_nxt;
      r_halt      <= w_halt_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_dren_nxt      = r_dren;
    w_dwen_nxt      = r_dwen;
    w_halt_nxt      = r_halt;
    w_stall_cnt_nxt = r_stall_cnt;
    w_pc_en         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (ihit) begin
          // halt outranks any data access decoded in the same instruction
          if (halt_i) begin
            w_state_nxt = HALTED;
            w_halt_nxt  = 1'b1;
            w_dren_nxt  = 1'b0;
            w_dwen_nxt  = 1'b0;
          end else if (dWENi) begin
            w_state_nxt = DREQ;
            w_dwen_nxt  = 1'b1;
            w_dren_nxt  = 1'b0;
          end else if (dRENi) begin
            w_state_nxt = DREQ;
            w_dren_nxt  = 1'b1;
            w_dwen_nxt  = 1'b0;
          end else begin
            w_pc_en = 1'b1;
          end
        end
      end

      DREQ: begin
        if (dhit) begin
          w_state_nxt = IDLE;
          w_dren_nxt  = 1'b0;
          w_dwen_nxt  = 1'b0;
          w_pc_en     = 1'b1;
        end else if (r_stall_cnt != CNT_MAX) begin
          w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
        end
      end

      HALTED: begin
        w_dren_nxt = 1'b0;
        w_dwen_nxt = 1'b0;
        w_halt_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = IDLE;
        w_dren_nxt  = 1'b0;
        w_dwen_nxt  = 1'b0;
      end
    endcase
  end

  assign dREN      = r_dren;
  assign dWEN      = r_dwen;
  assign halt      = r_halt;
  assign stall_cnt = r_stall_cnt;
  assign pcEN      = w_pc_en & nRST;
  assign iREN      = ~r_halt & nRST;

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: directed scenarios plus random instruction/memory traffic,
// every cycle compared against a transaction-level model of the sequencer.
module tb_request_unit;

  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             CLK;
  logic             nRST;
  logic             ihit;
  logic             dhit;
  logic             dRENi;
  logic             dWENi;
  logic             halt_i;
  logic             dREN;
  logic             dWEN;
  logic             iREN;
  logic             pcEN;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks;
  int n_errors;

  // model: pending request (0 none, 1 load, 2 store), halted flag, stall cycles
  int m_req;
  int m_halted;
  int m_cnt;

  request_unit #(.CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .ihit      (ihit),
    .dhit      (dhit),
    .dRENi     (dRENi),
    .dWENi     (dWENi),
    .halt_i    (halt_i),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .iREN      (iREN),
    .pcEN      (pcEN),
    .halt      (halt),
    .stall_cnt (stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_regs();
    check("dREN",      32'(dREN),      32'(m_req == 1));
    check("dWEN",      32'(dWEN),      32'(m_req == 2));
    check("halt",      32'(halt),      32'(m_halted));
    check("iREN",      32'(iREN),      32'(m_halted == 0));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  // Called at a falling edge: check state, apply inputs, check pcEN, advance model.
  task automatic cycle(input bit ih, input bit dh, input bit dr, input bit dw, input bit hi);
    bit exp_pc;
    check_regs();
    ihit = ih; dhit = dh; dRENi = dr; dWENi = dw; halt_i = hi;
    #1;
    exp_pc = 1'b0;
    if (m_halted == 0) begin
      if (m_req == 0) exp_pc = ih && !hi && !dr && !dw;
      else            exp_pc = dh;
    end
    check("pcEN", 32'(pcEN), 32'(exp_pc));
    if (m_halted == 0) begin
      if (m_req != 0) begin
        if (dh) m_req = 0;
        else if (m_cnt < CNT_SAT) m_cnt++;
      end else if (ih) begin
        if (hi)      m_halted = 1;
        else if (dw) m_req = 2;
        else if (dr) m_req = 1;
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    ihit = 1'b1; dhit = 1'b1; dRENi = 1'b0; dWENi = 1'b0; halt_i = 1'b0;
    #1;
    m_req = 0; m_halted = 0; m_cnt = 0;
    check("rst_dREN",  32'(dREN),      32'd0);
    check("rst_dWEN",  32'(dWEN),      32'd0);
    check("rst_halt",  32'(halt),      32'd0);
    check("rst_pcEN",  32'(pcEN),      32'd0);
    check("rst_iREN",  32'(iREN),      32'd0);
    check("rst_cnt",   32'(stall_cnt), 32'd0);
    ihit = 1'b0; dhit = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("rel_iREN", 32'(iREN), 32'd1);
    @(negedge CLK);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nRST = 1'b0;
    ihit = 1'b0; dhit = 1'b0; dRENi = 1'b0; dWENi = 1'b0; halt_i = 1'b0;
    @(negedge CLK);
    do_reset();

    // non-memory instruction and spurious dhit in IDLE
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);

    // load with two wait cycles, dhit on the third request cycle
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("load_cnt", 32'(stall_cnt), 32'd2);
    check("load_dREN_done", 32'(dREN), 32'd0);

    // store with both intents set, zero-wait
    cycle(1, 0, 1, 1, 0);
    check("store_dWEN", 32'(dWEN), 32'd1);
    check("store_dREN", 32'(dREN), 32'd0);
    cycle(0, 1, 0, 0, 0);
    check("store_cnt", 32'(stall_cnt), 32'd2);

    // ihit+halt_i during DREQ must be ignored
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // halt takes priority over a load
    cycle(1, 0, 1, 0, 1);
    check("halt_set", 32'(halt), 32'd1);
    check("halt_iREN", 32'(iREN), 32'd0);
    check("halt_dREN", 32'(dREN), 32'd0);
    cycle(1, 1, 1, 1, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    do_reset();

    // saturation then async reset mid-DREQ
    cycle(1, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
    check("sat_cnt", 32'(stall_cnt), 32'(CNT_SAT));
    check("sat_dREN", 32'(dREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("arst_dREN", 32'(dREN), 32'd0);
    check("arst_cnt", 32'(stall_cnt), 32'd0);
    check("arst_pcEN", 32'(pcEN), 32'd0);
    @(negedge CLK);
    do_reset();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit ih, dh, dr, dw, hi;
      ih = ($urandom_range(0, 1) == 1);
      dh = ($urandom_range(0, 2) == 0);
      dr = ($urandom_range(0, 1) == 1);
      dw = ($urandom_range(0, 2) == 0);
      hi = ($urandom_range(0, 40) == 0);
      cycle(ih, dh, dr, dw, hi);
      if (m_halted != 0 && $urandom_range(0, 5) == 0) do_reset();
    end
    check_regs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
